move_direction_sequencer: RTL and testbench

Registered, parametrised successor to the combinational direction decoder. Converts wide signed joystick/planner vectors (xDir, yDir) into the 3-bit move code from directions.vh, with a deadband on each axis, an N-sample stability filter, and a timed brake interval on any forward↔backward reversal. Sits between the navigation/planner logic and the motor drive block; the motor drive sees only committed, glitch-free MoveDir changes.

---
 rtl/move_direction_sequencer_pkg.sv | 54 +++++
 rtl/move_direction_sequencer_axis_quantizer.sv | 27 ++
 rtl/move_direction_sequencer.sv | 153 +++++++++++++++
 tb/tb_move_direction_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/move_direction_sequencer_pkg.sv
// Move codes, FSM state encoding and decode helpers shared by the direction sequencer.
// Pure combinational helpers: zero latency, no flow control.
package move_direction_sequencer_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_FWD   = 3'd1;
  localparam logic [2:0] DIR_BWD   = 3'd2;
  localparam logic [2:0] DIR_LFWD  = 3'd3;
  localparam logic [2:0] DIR_RFWD  = 3'd4;
  localparam logic [2:0] DIR_LBWD  = 3'd5;
  localparam logic [2:0] DIR_RBWD  = 3'd6;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BRAKE = 1'b1
  } state_t;

  function automatic logic is_fwd(input logic [2:0] d);
    return (d == DIR_FWD) || (d == DIR_LFWD) || (d == DIR_RFWD);
  endfunction

  function automatic logic is_bwd(input logic [2:0] d);
    return (d == DIR_BWD) || (d == DIR_LBWD) || (d == DIR_RBWD);
  endfunction

  function automatic logic is_reversal(input logic [2:0] from_dir, input logic [2:0] to_dir);
    return (is_fwd(from_dir) && is_bwd(to_dir)) || (is_bwd(from_dir) && is_fwd(to_dir));
  endfunction

  // Axis codes are 2-bit signed: 01 = +1, 11 = -1, 00 = 0.
  function automatic logic [2:0] map_dir(input logic [1:0] qx, input logic [1:0] qy);
    logic [2:0] d;
    d = DIR_NONE;
    case (qy)
      2'b01: begin
        case (qx)
          2'b11:   d = DIR_LFWD;
          2'b01:   d = DIR_RFWD;
          default: d = DIR_FWD;
        endcase
      end
      2'b11: begin
        case (qx)
          2'b11:   d = DIR_LBWD;
          2'b01:   d = DIR_RBWD;
          default: d = DIR_BWD;
        endcase
      end
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/move_direction_sequencer_axis_quantizer.sv
// Three-level axis quantiser with inclusive deadband; compares at W+1 bits so -2^(W-1) is safe.
// Purely combinational, no flow control.
module axis_quantizer #(
  parameter int W        = 8,
  parameter int DEADBAND = 16
) (
  input  logic signed [W-1:0] v,
  output logic        [1:0]   q
);

  localparam logic signed [W:0] DB_POS = (W+1)'(DEADBAND);
  localparam logic signed [W:0] DB_NEG = -DB_POS;

  logic signed [W:0] v_ext;

  assign v_ext = {v[W-1], v};

  always_comb begin
    q = 2'b00;
    if (v_ext > DB_POS) begin
      q = 2'b01;
    end else if (v_ext < DB_NEG) begin
      q = 2'b11;
    end
  end

endmodule

// File: rtl/move_direction_sequencer.sv
// Filters joystick vectors into committed move codes, braking through None on reversals.
// Commit visible one cycle after the STABLE_CYCLES-th equal sample; dirValid-gated, no backpressure; DIR_WATCHDOG_EN adds an idle timeout.
module move_direction_sequencer
  import move_direction_sequencer_pkg::*;
#(
  parameter int W              = 8,
  parameter int DEADBAND       = 16,
  parameter int STABLE_CYCLES  = 3,
  parameter int BRAKE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] xDir,
  input  logic signed [W-1:0] yDir,
  input  logic                dirValid,
  output logic        [2:0]   MoveDir,
  output logic                dirChanged,
  output logic                brakeActive,
  output logic                timedOut
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int BRK_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(STABLE_CYCLES);
  localparam logic [BRK_W-1:0] BRK_LOAD = BRK_W'((BRAKE_CYCLES > 0) ? BRAKE_CYCLES - 1 : 0);

  logic [1:0]       qx, qy;
  logic [2:0]       decoded;
  logic             qualified;
  logic             wd_fire;
  state_t           state_r, state_n;
  logic [2:0]       move_r, move_n, pending_r, pending_n, cand_r, cand_n;
  logic [RUN_W-1:0] run_r, run_n;
  logic [BRK_W-1:0] brk_r, brk_n;
  logic             chg_r;

  axis_quantizer #(.W(W), .DEADBAND(DEADBAND)) u_quant_x (.v(xDir), .q(qx));
  axis_quantizer #(.W(W), .DEADBAND(DEADBAND)) u_quant_y (.v(yDir), .q(qy));

  assign decoded = map_dir(qx, qy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_DRIVE;
      move_r    <= DIR_NONE;
      pending_r <= DIR_NONE;
      cand_r    <= DIR_NONE;
      run_r     <= '0;
      brk_r     <= '0;
      chg_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      move_r    <= move_n;
      pending_r <= pending_n;
      cand_r    <= cand_n;
      run_r     <= run_n;
      brk_r     <= brk_n;
      chg_r     <= (move_n != move_r);
    end
  end

  always_comb begin
    state_n   = state_r;
    move_n    = move_r;
    pending_n = pending_r;
    cand_n    = cand_r;
    run_n     = run_r;
    brk_n     = brk_r;
    qualified = 1'b0;

    if (dirValid) begin
      if (decoded == cand_r) begin
        if (run_r < RUN_SAT) run_n = run_r + 1'b1;
      end else begin
        cand_n = decoded;
        run_n  = RUN_W'(1);
      end
      qualified = (run_n >= RUN_SAT);
    end

    case (state_r)
      ST_DRIVE: begin
        if (qualified && (decoded != move_r)) begin
          if ((BRAKE_CYCLES > 0) && is_reversal(move_r, decoded)) begin
            move_n    = DIR_NONE;
            pending_n = decoded;
            brk_n     = BRK_LOAD;
            state_n   = ST_BRAKE;
          end else begin
            move_n = decoded;
          end
        end
      end
      ST_BRAKE: begin
        // A target qualifying on the exit edge still wins over the older pending one.
        if (qualified) pending_n = decoded;
        if (brk_r == '0) begin
          move_n  = pending_n;
          state_n = ST_DRIVE;
        end else begin
          brk_n = brk_r - 1'b1;
        end
      end
      default: state_n = ST_DRIVE;
    endcase

    if (wd_fire) begin
      move_n  = DIR_NONE;
      state_n = ST_DRIVE;
      cand_n  = DIR_NONE;
      run_n   = '0;
    end
  end

  always_comb begin
    MoveDir     = move_r;
    dirChanged  = chg_r;
    brakeActive = (state_r == ST_BRAKE);
  end

`ifdef DIR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            to_r;

  // Fires once on the TIMEOUT_CYCLES-th idle edge; the counter then parks at the limit.
  assign wd_fire  = !dirValid && (wd_cnt == WD_LIMIT - 1'b1);
  assign timedOut = to_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      to_r   <= 1'b0;
    end else if (dirValid) begin
      wd_cnt <= '0;
      to_r   <= 1'b0;
    end else begin
      if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) to_r <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire        = 1'b0;
  assign timedOut       = 1'b0;
`endif

endmodule

// File: tb/tb_move_direction_sequencer.sv
// Directed scoreboard bench for move_direction_sequencer (W=8, DEADBAND=16, STABLE=3, BRAKE=4, TIMEOUT=100).
module tb_move_direction_sequencer;

  typedef struct {
    string      tag;
    logic [2:0] mv;
    logic       chg;
    logic       brk;
    logic       to;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] xDir = '0;
  logic signed [7:0] yDir = '0;
  logic              dirValid = 1'b0;
  logic [2:0]        MoveDir;
  logic              dirChanged;
  logic              brakeActive;
  logic              timedOut;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  move_direction_sequencer #(
    .W(8), .DEADBAND(16), .STABLE_CYCLES(3), .BRAKE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .xDir(xDir), .yDir(yDir), .dirValid(dirValid),
    .MoveDir(MoveDir), .dirChanged(dirChanged), .brakeActive(brakeActive), .timedOut(timedOut)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string what, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int mv, input int chg, input int brk, input int to);
    exp_t e;
    e.tag = tag;
    e.mv  = 3'(mv);
    e.chg = 1'(chg);
    e.brk = 1'(brk);
    e.to  = 1'(to);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "MoveDir", MoveDir, e.mv);
      cmp(e.tag, "dirChanged", {2'b00, dirChanged}, {2'b00, e.chg});
      cmp(e.tag, "brakeActive", {2'b00, brakeActive}, {2'b00, e.brk});
      cmp(e.tag, "timedOut", {2'b00, timedOut}, {2'b00, e.to});
    end
  endtask

  // Drive one sample, push its expected outcome, then compare just after the sampling edge.
  task automatic step(input int x, input int y, input int v,
                      input int mv, input int chg, input int brk, input int to, input string tag);
    xDir     = 8'(x);
    yDir     = 8'(y);
    dirValid = 1'(v);
    push(tag, mv, chg, brk, to);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic async_reset(input string tag);
    push(tag, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    push("reset", 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, "post_reset");

    // Two forward samples then a centred one: nothing commits.
    step(0, 40, 1, 0, 0, 0, 0, "partial_1");
    step(0, 40, 1, 0, 0, 0, 0, "partial_2");
    step(0,  0, 1, 0, 0, 0, 0, "partial_drop");

    step(0, 40, 1, 0, 0, 0, 0, "fwd_1");
    step(0, 40, 1, 0, 0, 0, 0, "fwd_2");
    step(0, 40, 1, 1, 1, 0, 0, "fwd_3");
    step(0,  0, 0, 1, 0, 0, 0, "fwd_hold");

    // Same-group change goes straight through.
    step(-20, 40, 1, 1, 0, 0, 0, "lfwd_1");
    step(-20, 40, 1, 1, 0, 0, 0, "lfwd_2");
    step(-20, 40, 1, 3, 1, 0, 0, "lfwd_3");
    step(0, 40, 1, 3, 0, 0, 0, "refwd_1");
    step(0, 40, 1, 3, 0, 0, 0, "refwd_2");
    step(0, 40, 1, 1, 1, 0, 0, "refwd_3");

    // Reversal: four None cycles with brake, then RBackward.
    step(50, -50, 1, 1, 0, 0, 0, "rev_1");
    step(50, -50, 1, 1, 0, 0, 0, "rev_2");
    step(50, -50, 1, 0, 1, 1, 0, "rev_3");
    step(0, 0, 0, 0, 0, 1, 0, "brake_2");
    step(0, 0, 0, 0, 0, 1, 0, "brake_3");
    step(0, 0, 0, 0, 0, 1, 0, "brake_4");
    step(0, 0, 0, 6, 1, 0, 0, "brake_exit");
    step(0, 0, 0, 6, 0, 0, 0, "rbwd_hold");

    // Deadband edges.
    step(16, -16, 1, 6, 0, 0, 0, "db16_1");
    step(16, -16, 1, 6, 0, 0, 0, "db16_2");
    step(16, -16, 1, 0, 1, 0, 0, "db16_3");
    step(17, 17, 1, 0, 0, 0, 0, "db17_1");
    step(17, 17, 1, 0, 0, 0, 0, "db17_2");
    step(17, 17, 1, 4, 1, 0, 0, "db17_3");
    step(-128, -128, 1, 4, 0, 0, 0, "min_1");
    step(-128, -128, 1, 4, 0, 0, 0, "min_2");
    step(-128, -128, 1, 0, 1, 1, 0, "min_3_brake");
    step(0, 0, 0, 0, 0, 1, 0, "min_brake_2");

    // Reset in the middle of the brake discards the pending LBackward.
    async_reset("reset_mid_brake");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, "after_brake_reset");
    step(-128, -128, 1, 0, 0, 0, 0, "lbwd_1");
    step(-128, -128, 1, 0, 0, 0, 0, "lbwd_2");
    step(-128, -128, 1, 5, 1, 0, 0, "lbwd_3");

    async_reset("reset_mid_run");
    step(0, 0, 0, 0, 0, 0, 0, "after_run_reset");

    step(0, 40, 1, 0, 0, 0, 0, "wd_fwd_1");
    step(0, 40, 1, 0, 0, 0, 0, "wd_fwd_2");
    step(0, 40, 1, 1, 1, 0, 0, "wd_fwd_3");
`ifdef DIR_WATCHDOG_EN
    for (int i = 1; i < 100; i++) step(0, 0, 0, 1, 0, 0, 0, "wd_idle");
    step(0, 0, 0, 0, 1, 0, 1, "wd_fire");
    step(0, 0, 0, 0, 0, 0, 1, "wd_held");
    step(0, 0, 1, 0, 0, 0, 0, "wd_clear");
`else
    for (int i = 0; i < 110; i++) step(0, 0, 0, 1, 0, 0, 0, "idle_hold");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
